jt51_eg_cnt: RTL and testbench
==============================

# jt51_eg_cnt

Envelope-generator timebase for the operator pipeline: produces the global 15-bit envelope counter `eg_cnt` that every slot's rate/step logic indexes, and the per-slot memory that returns each slot's previous-frame counter LSB as `cnt_in`. The block is the producer side of the step interface: it drives `eg_cnt` and `cnt_in` into the step calculator and takes back `cnt_lsb`. It sits in the envelope generator next to the slot sequencer and runs off the chip clock with the shared clock enable.

## Interface
- `SLOTS`, 32: number of slots per frame, i.e. depth of the per-slot LSB memory (power of two, ≥4).
- `CNTW`, 15: width of `eg_cnt`.

- `clk` in 1: chip clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cen` in 1: clock enable; all state advances only on `clk` edges with `cen`=1.
- `zero` in 1: frame marker, high during the `cen` cycle of slot 0.
- `cnt_lsb` in 1: current slot's counter LSB from the step calculator.
- `eg_cnt` out CNTW: global envelope counter, constant across a frame.
- `cnt_in` out 1: `cnt_lsb` as written for the same slot one frame (SLOTS enabled cycles) earlier.
- `eg_stb` out 1: high for the whole frame in which `eg_cnt` was just advanced.
- `slot` out log2(SLOTS): index of the slot currently being processed.

## Operation
- Prescaler `div` (2 bits, 0..2): on each `cen`·`zero` edge, `div` ← 0 if `div`==2 else `div`+1. Value 3 is unreachable; if reached, treat as 2.
- Counter: on the `cen`·`zero` edge where `div`==2, `eg_cnt` ← `eg_cnt`+1; from 2^CNTW−1 it wraps to 1 (0 only after reset). Otherwise `eg_cnt` holds. One increment per 3 frames.
- `eg_stb`: on every `cen`·`zero` edge, `eg_stb` ← (`div`==2). Held between `zero` edges.
- Slot counter: on `cen` edges, `slot` ← 0 if `zero` is high, else `slot`+1 (modulo SLOTS). `zero` always resynchronises; a missing `zero` lets `slot` wrap naturally.
- LSB memory: SLOTS×1-bit shift register advanced on every `cen` edge; input `cnt_lsb`, output `cnt_in` = last stage. Not resynchronised by `zero`; depth alone fixes the one-frame delay.
- `cen`=0: every register holds, outputs constant.
- `zero` with `cen`=0: ignored.

## Timing
- Reset (async assert, sync to `clk` on release): `eg_cnt`=0, `div`=0, `eg_stb`=0, `slot`=0, all LSB memory stages 0 so `cnt_in`=0.
- `eg_cnt`, `eg_stb`, `slot` update at the `clk` edge sampling `cen`·`zero` and are visible in the next cycle, i.e. from slot 0's successor onward. Latency 1 `clk`.
- `cnt_in` is a registered output: the value of `cnt_lsb` sampled at enabled edge n appears after enabled edge n+SLOTS−1, so `cnt_in` seen during slot k equals `cnt_lsb` given during slot k of the previous frame.
- `zero` on consecutive enabled cycles is allowed. Each edge counts as a frame for `div`/`eg_cnt`. `slot` stays 0.
- Reset mid-frame clears everything immediately. The first `zero` after release gives `div`=1, with no increment.
- Frame of SLOTS enabled cycles at nominal rate. No handshake: `cnt_lsb` must be valid on every enabled edge.

## Test plan
- Reset then 9 frames of 32 enabled cycles, `zero` at slot 0 -> `eg_cnt` steps 0→1 at frame 3, →2 at frame 6, →3 at frame 9. `eg_stb`=1 only in frames 3, 6, 9.
- Preload by running until `eg_cnt`=0x7FFF, then 3 more frames -> `eg_cnt`=0x0001, never 0x0000.
- Drive `cnt_lsb` = slot[0] XOR frame[0] -> from frame 2 on, `cnt_in` in slot k equals the value driven in slot k one frame earlier for all 32 slots. In frame 1, `cnt_in`=0.
- `cen` toggling 1-of-4 cycles with `zero` held high over disabled cycles -> counts match the `cen`=1-always run exactly. `zero` with `cen`=0 has no effect.
- Assert `rst_n`=0 during slot 17 with `eg_cnt`=5 and `div`=2 -> all outputs 0 asynchronously. After release plus 3 frames, `eg_cnt`=1.
- Omit `zero` for one frame -> `slot` wraps 31→0 by itself. No `eg_cnt`/`div` change that frame; next `zero` resumes normally.

Source files
------------

// File: rtl/jt51_eg_cnt.sv
// Envelope-generator timebase: global envelope counter with a divide-by-3
// frame prescaler, slot index counter, and a one-frame per-slot LSB delay line.
module jt51_eg_cnt #(
  parameter int SLOTS = 32,
  parameter int CNTW  = 15,
  localparam int SW   = $clog2(SLOTS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            zero,
  input  logic            cnt_lsb,
  output logic [CNTW-1:0] eg_cnt,
  output logic            cnt_in,
  output logic            eg_stb,
  output logic [SW-1:0]   slot
);

  logic [1:0]       div;
  logic             div_tc;
  logic [SLOTS-1:0] lsb_mem;

  // div==3 is unreachable but is handled as the terminal count
  assign div_tc = (div >= 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= 2'd0;
      eg_stb <= 1'b0;
      eg_cnt <= '0;
    end else if (cen && zero) begin
      div    <= div_tc ? 2'd0 : div + 2'd1;
      eg_stb <= div_tc;
      if (div_tc) begin
        // zero is only ever seen straight out of reset
        eg_cnt <= (eg_cnt == {CNTW{1'b1}}) ? CNTW'(1) : eg_cnt + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (cen) begin
      slot <= zero ? '0 : slot + SW'(1);
    end
  end

  // Pure delay line: its depth alone aligns cnt_in with the same slot last frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsb_mem <= '0;
    end else if (cen) begin
      lsb_mem <= {lsb_mem[SLOTS-2:0], cnt_lsb};
    end
  end

  assign cnt_in = lsb_mem[SLOTS-1];

endmodule

// File: tb/tb_jt51_eg_cnt.sv
// Directed bench for jt51_eg_cnt: counter pacing, strobe, slot index, LSB delay,
// clock-enable gating, async reset, missing frame marker and counter wrap.
module tb_jt51_eg_cnt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cen = 1'b0;
  logic        zero = 1'b0;
  logic        cnt_lsb = 1'b0;
  logic [14:0] eg_cnt;
  logic        cnt_in;
  logic        eg_stb;
  logic [4:0]  slot;

  logic        cen_w = 1'b0;
  logic        zero_w = 1'b0;
  logic        lsb_w = 1'b0;
  logic [3:0]  eg_cnt_w;
  logic        cnt_in_w;
  logic        eg_stb_w;
  logic [1:0]  slot_w;

  int checks = 0;
  int errors = 0;
  int fr = 0;
  logic model [32];

  jt51_eg_cnt #(.SLOTS(32), .CNTW(15)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .cnt_lsb(cnt_lsb),
    .eg_cnt(eg_cnt), .cnt_in(cnt_in), .eg_stb(eg_stb), .slot(slot)
  );

  // Narrow instance so the counter wrap is reachable in a short run
  jt51_eg_cnt #(.SLOTS(4), .CNTW(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .cen(cen_w), .zero(zero_w), .cnt_lsb(lsb_w),
    .eg_cnt(eg_cnt_w), .cnt_in(cnt_in_w), .eg_stb(eg_stb_w), .slot(slot_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases after an edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_eg_cnt", 32'(eg_cnt), 32'd0);
    chk("rst_eg_stb", 32'(eg_stb), 32'd0);
    chk("rst_slot",   32'(slot),   32'd0);
    chk("rst_cnt_in", 32'(cnt_in), 32'd0);
    cen = 1'b0;
    zero = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 1'b0;
  endtask

  task automatic run_frame(input int n_cyc, input int gap, input bit with_zero,
                           input logic [14:0] exp_cnt, input logic exp_stb);
    logic lsb;
    for (int k = 0; k < n_cyc; k++) begin
      for (int g = 0; g < gap; g++) begin
        cen = 1'b0;
        zero = 1'b1;
        cnt_lsb = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        chk("gap_cnt_in", 32'(cnt_in), 32'(model[k]));
        if (k > 0) chk("gap_slot", 32'(slot), 32'(k - 1));
      end
      chk("cnt_in", 32'(cnt_in), 32'(model[k]));
      lsb = k[0] ^ fr[0];
      model[k] = lsb;
      cen = 1'b1;
      zero = with_zero && (k == 0);
      cnt_lsb = lsb;
      @(posedge clk);
      #1;
      chk("slot", 32'(slot), 32'(k));
      if (k == 0 || k == n_cyc - 1) begin
        chk("eg_cnt", 32'(eg_cnt), 32'(exp_cnt));
        chk("eg_stb", 32'(eg_stb), 32'(exp_stb));
      end
    end
    cen = 1'b0;
    zero = 1'b0;
    fr++;
  endtask

  initial begin
    int c;
    // Nominal rate: one increment every third frame
    do_reset();
    for (int f = 1; f <= 9; f++)
      run_frame(32, 0, 1'b1, 15'(f / 3), (f % 3) == 0);

    // cen one cycle in four, zero held high while disabled
    do_reset();
    for (int f = 1; f <= 16; f++)
      run_frame(32, 3, 1'b1, 15'(f / 3), (f % 3) == 0);
    run_frame(17, 3, 1'b1, 15'd5, 1'b0);
    chk("pre_rst_eg_cnt", 32'(eg_cnt), 32'd5);
    chk("pre_rst_slot",   32'(slot),   32'd16);

    // Reset during slot 17 with eg_cnt=5, div=2
    do_reset();
    run_frame(32, 0, 1'b1, 15'd0, 1'b0);
    run_frame(32, 0, 1'b1, 15'd0, 1'b0);
    run_frame(32, 0, 1'b1, 15'd1, 1'b1);

    // Frame without zero: slot wraps, counter and strobe hold
    run_frame(32, 0, 1'b0, 15'd1, 1'b1);
    run_frame(32, 0, 1'b1, 15'd1, 1'b0);
    run_frame(32, 0, 1'b1, 15'd1, 1'b0);
    run_frame(32, 0, 1'b1, 15'd2, 1'b1);

    // Wrap on the 4-bit instance: zero every cycle, 3 cycles per increment
    do_reset();
    cen_w = 1'b1;
    zero_w = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      @(posedge clk);
      #1;
      c = i / 3;
      if (c > 15) c = c - 15;
      chk("wrap_eg_cnt", 32'(eg_cnt_w), 32'(c));
      chk("wrap_slot", 32'(slot_w), 32'd0);
    end
    chk("wrap_final", 32'(eg_cnt_w), 32'd1);
    cen_w = 1'b0;
    zero_w = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
